// File: rtl/forward_ctrl_pkg.sv
// Shared definitions for the forward grant controller and the forward packet modules.
package forward_ctrl_pkg;

  localparam int unsigned FWD_BYTE_W = 32;

  localparam logic [FWD_BYTE_W-1:0] DEF_MAX_GRANT_BYTE = 32'd4096;
  localparam logic [FWD_BYTE_W-1:0] DEF_MIN_GRANT_BYTE = 32'd64;
  localparam logic [15:0]           DEF_TIMEOUT_CYC    = 16'd65535;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT    = 2'd1,
    ST_WAIT_FIN = 2'd2
  } fwd_state_e;

  function automatic logic [FWD_BYTE_W-1:0] min_bytes(
    input logic [FWD_BYTE_W-1:0] a,
    input logic [FWD_BYTE_W-1:0] b
  );
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/forward_grant_ctrl_rr_arb2.sv
// Two-input round-robin arbiter: a lone requester wins, a tie goes to the port not granted last.
module rr_arb2 (
  input  logic [1:0] pending_i,
  input  logic       last_i,
  output logic [1:0] grant_o
);

  // One-hot grant from the pending vector and the last-granted pointer
  always_comb begin
    grant_o = pending_i;
    if (pending_i == 2'b11) begin
      grant_o = last_i ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/forward_grant_ctrl.sv
// Forward handshake responder: arbitrates two ports, hands out byte budget, supervises finish.
module forward_grant_ctrl
  import forward_ctrl_pkg::*;
#(
  parameter logic [FWD_BYTE_W-1:0] MAX_GRANT_BYTE = DEF_MAX_GRANT_BYTE,
  parameter logic [FWD_BYTE_W-1:0] MIN_GRANT_BYTE = DEF_MIN_GRANT_BYTE,
  parameter logic [15:0]           TIMEOUT_CYC    = DEF_TIMEOUT_CYC
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_slot_start,
  input  logic [FWD_BYTE_W-1:0] i_slot_byte_budget,
  input  logic                  i_port0_forward_req,
  output logic                  o_port0_forward_resp,
  input  logic                  i_port0_forward_finish,
  output logic [FWD_BYTE_W-1:0] o_port0_forward_byte,
  output logic                  o_port0_forward_byte_valid,
  input  logic                  i_port1_forward_req,
  output logic                  o_port1_forward_resp,
  input  logic                  i_port1_forward_finish,
  output logic [FWD_BYTE_W-1:0] o_port1_forward_byte,
  output logic                  o_port1_forward_byte_valid,
  output logic [FWD_BYTE_W-1:0] o_remain_byte,
  output logic                  o_busy,
  output logic                  o_timeout
);

  fwd_state_e            state_q, state_d;
  logic [1:0]            pend_q, pend_d;
  logic [1:0]            block_q, block_d;
  logic                  sel_q, sel_d;
  logic                  last_q, last_d;
  logic [1:0]            resp_q, resp_d;
  logic [FWD_BYTE_W-1:0] byte0_q, byte0_d;
  logic [FWD_BYTE_W-1:0] byte1_q, byte1_d;
  logic [FWD_BYTE_W-1:0] remain_q, remain_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [1:0]            req;
  logic [1:0]            arbGrant;
  logic [FWD_BYTE_W-1:0] grantAmt;
  logic [FWD_BYTE_W-1:0] issuedAmt;
  logic                  finHit;
  logic                  timeoutHit;

  assign req       = {i_port1_forward_req, i_port0_forward_req};
  assign grantAmt  = min_bytes(remain_q, MAX_GRANT_BYTE);
  assign issuedAmt = byte0_q | byte1_q;

  rr_arb2 u_arb (
    .pending_i (pend_q),
    .last_i    (last_q),
    .grant_o   (arbGrant)
  );

  // Next-state logic: request latching, grant issue, budget accounting and finish supervision
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    block_d    = block_q;
    sel_d      = sel_q;
    last_d     = last_q;
    resp_d     = 2'b00;
    byte0_d    = '0;
    byte1_d    = '0;
    remain_d   = remain_q;
    cnt_d      = cnt_q;
    finHit     = 1'b0;
    timeoutHit = 1'b0;

    // A held request only re-latches after it has dropped once following its grant
    for (int n = 0; n < 2; n++) begin
      if (req[n] && !block_q[n]) pend_d[n] = 1'b1;
      if (!req[n])               block_d[n] = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if ((pend_q != 2'b00) && (remain_q >= MIN_GRANT_BYTE)) begin
          state_d = ST_GRANT;
          sel_d   = arbGrant[1];
          resp_d  = arbGrant;
          if (arbGrant[1]) byte1_d = grantAmt;
          else             byte0_d = grantAmt;
        end
      end
      ST_GRANT: begin
        pend_d[sel_q]  = 1'b0;
        block_d[sel_q] = req[sel_q];
        last_d         = sel_q;
        cnt_d          = '0;
        remain_d       = (remain_q > issuedAmt) ? (remain_q - issuedAmt) : '0;
        state_d        = ST_WAIT_FIN;
      end
      ST_WAIT_FIN: begin
        finHit = sel_q ? i_port1_forward_finish : i_port0_forward_finish;
        if (finHit) begin
          state_d = ST_IDLE;
        end else if (cnt_q == (TIMEOUT_CYC - 16'd1)) begin
          timeoutHit = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (i_slot_start) remain_d = i_slot_byte_budget;
  end

  // State and output registers; port0 wins the first tie after reset
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= ST_IDLE;
      pend_q   <= 2'b00;
      block_q  <= 2'b00;
      sel_q    <= 1'b0;
      last_q   <= 1'b1;
      resp_q   <= 2'b00;
      byte0_q  <= '0;
      byte1_q  <= '0;
      remain_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      block_q  <= block_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      resp_q   <= resp_d;
      byte0_q  <= byte0_d;
      byte1_q  <= byte1_d;
      remain_q <= remain_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_port0_forward_resp       = resp_q[0];
  assign o_port0_forward_byte_valid = resp_q[0];
  assign o_port0_forward_byte       = byte0_q;
  assign o_port1_forward_resp       = resp_q[1];
  assign o_port1_forward_byte_valid = resp_q[1];
  assign o_port1_forward_byte       = byte1_q;
  assign o_remain_byte              = remain_q;
  assign o_busy                     = (state_q != ST_IDLE);
  assign o_timeout                  = timeoutHit;

endmodule

// File: tb/tb_forward_grant_ctrl.sv
// Directed bench for forward_grant_ctrl: cycle table plus timeout and reset corner sequences.
module tb_forward_grant_ctrl;

  typedef struct {
    logic        rstN;
    logic        slot;
    logic [31:0] budget;
    logic        req0;
    logic        req1;
    logic        fin0;
    logic        fin1;
    logic        eResp0;
    logic        eResp1;
    logic [31:0] eByte0;
    logic [31:0] eByte1;
    logic [31:0] eRemain;
    logic        eBusy;
    logic        eTimeout;
  } vec_t;

  logic        clock;
  logic        resetN;
  logic        slotStart;
  logic [31:0] slotBudget;
  logic        req0, req1, fin0, fin1;
  logic        resp0, resp1, valid0, valid1;
  logic [31:0] byte0, byte1, remain;
  logic        busy, timeout;

  int total = 0;
  int bad   = 0;
  vec_t vecs[$];

  forward_grant_ctrl #(
    .MAX_GRANT_BYTE (32'd4096),
    .MIN_GRANT_BYTE (32'd64),
    .TIMEOUT_CYC    (16'd16)
  ) dut (
    .i_clk                      (clock),
    .i_rst                      (resetN),
    .i_slot_start               (slotStart),
    .i_slot_byte_budget         (slotBudget),
    .i_port0_forward_req        (req0),
    .o_port0_forward_resp       (resp0),
    .i_port0_forward_finish     (fin0),
    .o_port0_forward_byte       (byte0),
    .o_port0_forward_byte_valid (valid0),
    .i_port1_forward_req        (req1),
    .o_port1_forward_resp       (resp1),
    .i_port1_forward_finish     (fin1),
    .o_port1_forward_byte       (byte1),
    .o_port1_forward_byte_valid (valid1),
    .o_remain_byte              (remain),
    .o_busy                     (busy),
    .o_timeout                  (timeout)
  );

  // Free-running 10 ns clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=still running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(
    input logic rstN, input logic slot, input logic [31:0] budget,
    input logic r0, input logic r1, input logic f0, input logic f1,
    input logic eR0, input logic eR1, input logic [31:0] eB0, input logic [31:0] eB1,
    input logic [31:0] eRem, input logic eBusy, input logic eTo
  );
    vec_t v;
    v.rstN = rstN; v.slot = slot; v.budget = budget;
    v.req0 = r0; v.req1 = r1; v.fin0 = f0; v.fin1 = f1;
    v.eResp0 = eR0; v.eResp1 = eR1; v.eByte0 = eB0; v.eByte1 = eB1;
    v.eRemain = eRem; v.eBusy = eBusy; v.eTimeout = eTo;
    return v;
  endfunction

  // Drive every DUT input from one record
  task automatic applyStimulus(input vec_t v);
    resetN     = v.rstN;
    slotStart  = v.slot;
    slotBudget = v.budget;
    req0       = v.req0;
    req1       = v.req1;
    fin0       = v.fin0;
    fin1       = v.fin1;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock: drive just after the rising edge, leave sampling to the caller at the falling edge
  task automatic stepCycle(input vec_t v);
    @(posedge clock);
    #1;
    applyStimulus(v);
    @(negedge clock);
  endtask

  // Packs all outputs; byte buses only matter while their valid is expected
  function automatic logic [127:0] packAct(input vec_t v);
    return {26'd0, resp0, valid0, (v.eResp0 ? byte0 : 32'd0),
            resp1, valid1, (v.eResp1 ? byte1 : 32'd0), remain, busy, timeout};
  endfunction

  function automatic logic [127:0] packExp(input vec_t v);
    return {26'd0, v.eResp0, v.eResp0, (v.eResp0 ? v.eByte0 : 32'd0),
            v.eResp1, v.eResp1, (v.eResp1 ? v.eByte1 : 32'd0), v.eRemain, v.eBusy, v.eTimeout};
  endfunction

  // Main sequence: reset, table of cycles, then hand-written corner cases
  initial begin
    vec_t idle, v;
    idle = mk(1,0,0, 0,0,0,0, 0,0,0,0,0,0,0);

    // rst slot budget   r0 r1 f0 f1 | eR0 eR1 eB0 eB1 eRem eBusy eTo
    vecs.push_back(mk(1,1,10000, 0,0,0,0, 0,0,0,0,0,0,0));          // 0 load 10000
    vecs.push_back(mk(1,0,0,     1,0,0,0, 0,0,0,0,10000,0,0));      // 1 req0 pulse
    vecs.push_back(mk(1,0,0,     0,0,0,0, 0,0,0,0,10000,0,0));      // 2
    vecs.push_back(mk(1,0,0,     0,0,0,0, 1,0,4096,0,10000,1,0));   // 3 resp0 at +2
    vecs.push_back(mk(1,0,0,     0,0,0,0, 0,0,0,0,5904,1,0));       // 4
    vecs.push_back(mk(1,0,0,     0,0,1,0, 0,0,0,0,5904,1,0));       // 5 finish0
    vecs.push_back(mk(0,0,0,     0,0,0,0, 0,0,0,0,0,0,0));          // 6 reset
    vecs.push_back(mk(1,1,10000, 1,1,0,0, 0,0,0,0,0,0,0));          // 7 both req
    vecs.push_back(mk(1,0,0,     0,0,0,0, 0,0,0,0,10000,0,0));      // 8
    vecs.push_back(mk(1,0,0,     0,0,0,0, 1,0,4096,0,10000,1,0));   // 9 port0 wins tie
    vecs.push_back(mk(1,0,0,     0,0,1,0, 0,0,0,0,5904,1,0));       // 10 finish0
    vecs.push_back(mk(1,0,0,     0,0,0,0, 0,0,0,0,5904,0,0));       // 11
    vecs.push_back(mk(1,0,0,     0,0,0,0, 0,1,0,4096,5904,1,0));    // 12 port1 granted
    vecs.push_back(mk(1,0,0,     0,0,0,1, 0,0,0,0,1808,1,0));       // 13 finish1
    vecs.push_back(mk(1,0,0,     1,1,0,0, 0,0,0,0,1808,0,0));       // 14 both again
    vecs.push_back(mk(1,0,0,     0,0,0,0, 0,0,0,0,1808,0,0));       // 15
    vecs.push_back(mk(1,0,0,     0,0,0,0, 1,0,1808,0,1808,1,0));    // 16 rest of budget
    vecs.push_back(mk(1,0,0,     0,0,1,0, 0,0,0,0,0,1,0));          // 17 finish0
    vecs.push_back(mk(1,0,0,     0,0,0,1, 0,0,0,0,0,0,0));          // 18 finish in IDLE ignored
    vecs.push_back(mk(1,1,50,    0,0,0,0, 0,0,0,0,0,0,0));          // 19 load 50
    vecs.push_back(mk(1,0,0,     0,1,0,0, 0,0,0,0,50,0,0));         // 20 req1, budget too low
    vecs.push_back(mk(1,0,0,     0,0,0,0, 0,0,0,0,50,0,0));         // 21
    vecs.push_back(mk(1,1,200,   0,0,0,0, 0,0,0,0,50,0,0));         // 22 load 200
    vecs.push_back(mk(1,0,0,     0,0,0,0, 0,0,0,0,200,0,0));        // 23
    vecs.push_back(mk(1,0,0,     0,0,0,0, 0,1,0,200,200,1,0));      // 24 resp1 = 200
    vecs.push_back(mk(1,0,0,     0,0,0,1, 0,0,0,0,0,1,0));          // 25 finish1
    vecs.push_back(mk(1,1,3000,  1,0,0,0, 0,0,0,0,0,0,0));          // 26 load 3000 + req0
    vecs.push_back(mk(1,0,0,     0,0,0,0, 0,0,0,0,3000,0,0));       // 27
    vecs.push_back(mk(1,1,8000,  0,0,0,0, 1,0,3000,0,3000,1,0));    // 28 reload in GRANT
    vecs.push_back(mk(1,0,0,     0,0,0,1, 0,0,0,0,8000,1,0));       // 29 wrong-port finish
    vecs.push_back(mk(1,0,0,     0,0,1,0, 0,0,0,0,8000,1,0));       // 30 finish0
    vecs.push_back(mk(1,0,0,     0,0,0,0, 0,0,0,0,8000,0,0));       // 31

    v = idle;
    v.rstN = 1'b0;
    applyStimulus(v);
    repeat (3) @(negedge clock);
    checkOutput("reset_state", packAct(v), packExp(v));

    foreach (vecs[i]) begin
      stepCycle(vecs[i]);
      checkOutput($sformatf("row%0d", i), packAct(vecs[i]), packExp(vecs[i]));
    end

    // Timeout: grant port0, never finish it; a port1 finish along the way is ignored
    v = idle; v.req0 = 1'b1;
    stepCycle(v);
    stepCycle(idle);
    stepCycle(idle);
    checkOutput("to_resp0", {resp0, byte0}, {1'b1, 32'd4096});
    for (int k = 1; k <= 16; k++) begin
      v = idle;
      if (k == 3) v.fin1 = 1'b1;
      stepCycle(v);
      checkOutput($sformatf("to_wait%0d", k), {busy, timeout}, {1'b1, (k == 16)});
    end
    stepCycle(idle);
    checkOutput("to_after", {busy, timeout, remain}, {1'b0, 1'b0, 32'd3904});

    // Finish in the very cycle the counter expires: finish wins
    v = idle; v.req0 = 1'b1;
    stepCycle(v);
    stepCycle(idle);
    stepCycle(idle);
    checkOutput("ft_resp0", {resp0, byte0}, {1'b1, 32'd3904});
    for (int k = 1; k <= 16; k++) begin
      v = idle;
      if (k == 16) v.fin0 = 1'b1;
      stepCycle(v);
      if (k == 16) checkOutput("ft_same_cycle", {busy, timeout}, {1'b1, 1'b0});
    end
    stepCycle(idle);
    checkOutput("ft_after", {busy, timeout, remain}, {1'b0, 1'b0, 32'd0});

    // Reset during WAIT_FIN with port0 pending, then a clean port1 grant
    v = idle; v.slot = 1'b1; v.budget = 5000; v.req1 = 1'b1;
    stepCycle(v);
    stepCycle(idle);
    stepCycle(idle);
    checkOutput("rs_resp1", {resp1, byte1}, {1'b1, 32'd4096});
    v = idle; v.req0 = 1'b1;
    stepCycle(v);
    @(posedge clock);
    #1;
    v = idle; v.rstN = 1'b0;
    applyStimulus(v);
    #1;
    checkOutput("rs_async", {resp0, resp1, valid0, valid1, busy, timeout, remain},
                {6'b000000, 32'd0});
    @(negedge clock);
    v = idle; v.slot = 1'b1; v.budget = 1000; v.req1 = 1'b1;
    stepCycle(v);
    stepCycle(idle);
    checkOutput("rs_idle", {resp0, resp1, busy, remain}, {3'b000, 32'd1000});
    stepCycle(idle);
    checkOutput("rs_regrant", {resp0, resp1, valid1, byte1, busy}, {3'b011, 32'd1000, 1'b1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/forward_grant_ctrl.md
Name: forward_grant_ctrl

Overview:
- Responder for the per-port forward handshake (req / resp / finish / byte budget) issued by the forward packet modules.
- Serves two requesting ports with round-robin arbitration and a per-slot byte budget.
- One grant outstanding at a time; supervised by a finish timeout.
- Sits in the mem_manager scheduling path, one instance per forwarding clock domain group.

Parameters:
MAX_GRANT_BYTE, 32'd4096, maximum bytes allotted per grant
MIN_GRANT_BYTE, 32'd64, minimum remaining budget required to issue a grant
TIMEOUT_CYC, 16'd65535, cycles to wait for finish before forced release

Ports:
i_clk  in  1  single clock
i_rst  in  1  reset; asynchronous, active-low
i_slot_start  in  1  one-cycle pulse; reload budget
i_slot_byte_budget  in  32  budget loaded on i_slot_start
i_port0_forward_req  in  1  port0 request (pulse or level)
o_port0_forward_resp  out  1  one-cycle grant pulse
i_port0_forward_finish  in  1  one-cycle finish pulse
o_port0_forward_byte  out  32  bytes allotted
o_port0_forward_byte_valid  out  1  qualifies o_port0_forward_byte
i_port1_forward_req  in  1  port1 request
o_port1_forward_resp  out  1  port1 grant pulse
i_port1_forward_finish  in  1  port1 finish pulse
o_port1_forward_byte  out  32  bytes allotted
o_port1_forward_byte_valid  out  1  qualifies o_port1_forward_byte
o_remain_byte  out  32  current remaining budget
o_busy  out  1  grant outstanding (GRANT or WAIT_FIN)
o_timeout  out  1  one-cycle pulse on forced release

Behaviour:
- Reset (i_rst=0, async):
  - All outputs 0; remain=0; pending=00; state IDLE.
  - Round-robin pointer set so port0 wins the first tie.
- Pending latch: i_portN_forward_req=1 sets pending[N]. pending[N] clears in the cycle its grant is issued. A request held across the grant re-latches only after it deasserts and reasserts (edge-detect once granted).
- States:
  - IDLE: if pending!=0 and remain>=MIN_GRANT_BYTE, go to GRANT.
    - Port selection: single pending port wins; both pending, the port not last granted wins.
  - GRANT (1 cycle): registered outputs o_portN_forward_resp=1 and o_portN_forward_byte_valid=1 for the selected port.
    - o_portN_forward_byte = min(remain, MAX_GRANT_BYTE).
    - remain -= that value; pointer updated; timeout counter cleared.
    - Next state WAIT_FIN.
  - WAIT_FIN:
    - i_portN_forward_finish from the granted port: go to IDLE.
    - Finish from the other port: ignored.
    - Counter reaches TIMEOUT_CYC-1: o_timeout pulse, go to IDLE.
- Latency: request first high in cycle k while IDLE with sufficient budget -> resp/byte_valid high in cycle k+2, for exactly 1 cycle.
- Budget:
  - i_slot_start loads remain=i_slot_byte_budget in any state.
  - Coinciding with GRANT: reload wins (no subtraction); the grant pulse and byte value are still issued.
- Boundaries:
  - remain<MIN_GRANT_BYTE: requests stay pending, no resp, until the next slot_start.
  - remain between MIN_GRANT_BYTE and MAX_GRANT_BYTE: grant = remain, remain becomes 0.
  - Finish arriving while in IDLE or GRANT: ignored.
  - Finish and timeout in the same cycle: finish wins, no o_timeout.
  - Reset mid-grant: immediate return to reset values; pending requests lost.
- o_busy = (state != IDLE). o_remain_byte is the registered remain.

Decomposition:
- Shared package forward_ctrl_pkg:
  - state encoding (IDLE/GRANT/WAIT_FIN)
  - default MAX_GRANT_BYTE / MIN_GRANT_BYTE
  - the forward-byte width constant (32), also used by the forward packet modules
- One natural sub-module: rr_arb2 (2-input round-robin arbiter: pending, pointer -> one-hot grant).

Test Plan:
- Budget 10000 on slot_start, port0 req pulse -> resp0 at +2 cycles, byte0=4096, remain=5904; finish0 -> IDLE, o_busy=0.
- Both reqs in same cycle, budget 10000 -> port0 granted 4096; after finish0, port1 granted 4096, remain=1808. Next cycle both again -> port0 gets 1808, remain=0.
- Budget 50 (<64), port1 req -> no resp. Slot_start with 200 -> resp1 with byte1=200 two cycles later.
- Grant to port0, no finish, TIMEOUT_CYC=16 -> o_timeout pulses 16 cycles after resp0, FSM IDLE. Finish1 during wait is ignored.
- slot_start (budget 8000) in the GRANT cycle, remain was 3000 -> byte0=3000, remain=8000 afterwards.
- Assert i_rst low during WAIT_FIN -> all outputs 0 asynchronously, pending cleared. After release, a port1 req is granted normally.
